// File: rtl/dkong3_snd_rom_arb.sv
// dkong3_snd_rom_arb
//
// Shares one 16 KB single-port synchronous program memory between the two
// 2A03 sound sub CPUs (sub 1 ROM 5L in the lower 8 KB, sub 2 ROM 6M in the
// upper 8 KB) and the ROM download path.
//
// Ports:
//   I_CLK_24M               sole clock, rising edge
//   I_RST                   synchronous active-high reset
//   I_SUB1_REQ/I_SUB1_ADDR  sub 1 read strobe and 13-bit byte address
//   I_SUB2_REQ/I_SUB2_ADDR  sub 2 read strobe and 13-bit byte address
//   I_DL_ACTIVE             download in progress, holds off sub reads
//   I_DLADDR/I_DLDATA/I_DLWR download address, byte and write strobe
//   O_MEM_ADDR/O_MEM_DO     memory address (bit 13 selects sub 2) and write byte
//   O_MEM_WE/O_MEM_RE       memory write / read enables
//   I_MEM_DI                memory read byte, valid MEM_LAT cycles after RE
//   O_SUBn_DO/O_SUBn_VALID  last fetched byte per sub and its update pulse
//   O_DL_OVF                sticky: an unserved download byte was overwritten
//   O_BUSY                  access in progress or any request pending
//
// Request semantics: every request input is a one-cycle strobe with no
// back-pressure. A strobe is latched into a pending flag on the edge it is
// sampled (address/data overwritten on that edge) and the flag is held until
// the arbiter grants it; a strobe on the same edge as the grant re-arms the
// flag. The result comes back as a one-cycle VALID pulse with the byte held
// on the matching DO output until that sub's next fetch completes.

module dkong3_snd_rom_arb #(
    parameter logic [16:0] SUB1_BASE = 17'h0A000,
    parameter logic [16:0] SUB2_BASE = 17'h0C000,
    parameter int          MEM_LAT   = 1
) (
    input  logic        I_CLK_24M,
    input  logic        I_RST,
    input  logic        I_SUB1_REQ,
    input  logic [12:0] I_SUB1_ADDR,
    input  logic        I_SUB2_REQ,
    input  logic [12:0] I_SUB2_ADDR,
    input  logic        I_DL_ACTIVE,
    input  logic [16:0] I_DLADDR,
    input  logic [7:0]  I_DLDATA,
    input  logic        I_DLWR,
    output logic [13:0] O_MEM_ADDR,
    output logic [7:0]  O_MEM_DO,
    output logic        O_MEM_WE,
    output logic        O_MEM_RE,
    input  logic [7:0]  I_MEM_DI,
    output logic [7:0]  O_SUB1_DO,
    output logic        O_SUB1_VALID,
    output logic [7:0]  O_SUB2_DO,
    output logic        O_SUB2_VALID,
    output logic        O_DL_OVF,
    output logic        O_BUSY
);

    localparam logic [1:0]  LAT_CNT = 2'(MEM_LAT);
    localparam logic [16:0] WIN_SZ  = 17'h02000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WAIT = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        p1;
    logic [12:0] p1_addr;
    logic        p2;
    logic [12:0] p2_addr;
    logic        pd;
    logic [13:0] pd_addr;
    logic [7:0]  pd_data;

    // rr = 0 favours sub 1 on a tie, rr = 1 favours sub 2.
    logic        rr;
    // Sub that owns the read in flight: 0 = sub 1, 1 = sub 2.
    logic        gnt_id;
    logic [1:0]  cnt;

    logic        gnt_pd;
    logic        gnt_s1;
    logic        gnt_s2;
    logic        cap;

    // Download window decode. Sub 1 wins if the windows were ever overlapped.
    logic [16:0] off1;
    logic [16:0] off2;
    logic        in1;
    logic        in2;
    logic        dl_hit;
    logic [13:0] dl_map;

    assign off1   = I_DLADDR - SUB1_BASE;
    assign off2   = I_DLADDR - SUB2_BASE;
    assign in1    = (I_DLADDR >= SUB1_BASE) && (off1 < WIN_SZ);
    assign in2    = (I_DLADDR >= SUB2_BASE) && (off2 < WIN_SZ);
    assign dl_hit = I_DLWR && (in1 || in2);
    assign dl_map = in1 ? {1'b0, off1[12:0]} : {1'b1, off2[12:0]};

    always_comb begin
        state_nx = state;
        gnt_pd   = 1'b0;
        gnt_s1   = 1'b0;
        gnt_s2   = 1'b0;
        cap      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pd) begin
                    gnt_pd   = 1'b1;
                    state_nx = ST_WR;
                end else if (!I_DL_ACTIVE && (p1 || p2)) begin
                    if (p1 && (!p2 || !rr)) gnt_s1 = 1'b1;
                    else                    gnt_s2 = 1'b1;
                    state_nx = ST_RD;
                end
            end
            ST_WR:   state_nx = ST_IDLE;
            ST_RD:   state_nx = ST_WAIT;
            ST_WAIT: begin
                // <= guards against a zero count ever wrapping the counter.
                if (cnt <= 2'd1) begin
                    cap      = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK_24M) begin
        if (I_RST) begin
            state        <= ST_IDLE;
            p1           <= 1'b0;
            p1_addr      <= '0;
            p2           <= 1'b0;
            p2_addr      <= '0;
            pd           <= 1'b0;
            pd_addr      <= '0;
            pd_data      <= '0;
            rr           <= 1'b0;
            gnt_id       <= 1'b0;
            cnt          <= '0;
            O_MEM_ADDR   <= '0;
            O_MEM_DO     <= '0;
            O_MEM_WE     <= 1'b0;
            O_MEM_RE     <= 1'b0;
            O_SUB1_DO    <= '0;
            O_SUB1_VALID <= 1'b0;
            O_SUB2_DO    <= '0;
            O_SUB2_VALID <= 1'b0;
            O_DL_OVF     <= 1'b0;
        end else begin
            state        <= state_nx;
            O_MEM_WE     <= 1'b0;
            O_MEM_RE     <= 1'b0;
            O_SUB1_VALID <= 1'b0;
            O_SUB2_VALID <= 1'b0;

            if (gnt_pd) begin
                O_MEM_ADDR <= pd_addr;
                O_MEM_DO   <= pd_data;
                O_MEM_WE   <= 1'b1;
            end else if (gnt_s1) begin
                O_MEM_ADDR <= {1'b0, p1_addr};
                O_MEM_RE   <= 1'b1;
                gnt_id     <= 1'b0;
                rr         <= 1'b1;
            end else if (gnt_s2) begin
                O_MEM_ADDR <= {1'b1, p2_addr};
                O_MEM_RE   <= 1'b1;
                gnt_id     <= 1'b1;
                rr         <= 1'b0;
            end

            if (state == ST_RD)        cnt <= LAT_CNT;
            else if (state == ST_WAIT) cnt <= cnt - 2'd1;

            if (cap) begin
                if (gnt_id) begin
                    O_SUB2_DO    <= I_MEM_DI;
                    O_SUB2_VALID <= 1'b1;
                end else begin
                    O_SUB1_DO    <= I_MEM_DI;
                    O_SUB1_VALID <= 1'b1;
                end
            end

            // Set has priority over the clear from a grant on the same edge.
            if (I_SUB1_REQ) begin
                p1      <= 1'b1;
                p1_addr <= I_SUB1_ADDR;
            end else if (gnt_s1) begin
                p1 <= 1'b0;
            end

            if (I_SUB2_REQ) begin
                p2      <= 1'b1;
                p2_addr <= I_SUB2_ADDR;
            end else if (gnt_s2) begin
                p2 <= 1'b0;
            end

            // A byte being granted this edge is already on its way to the
            // memory, so replacing it is not an overflow.
            if (dl_hit) begin
                pd      <= 1'b1;
                pd_addr <= dl_map;
                pd_data <= I_DLDATA;
                if (pd && !gnt_pd) O_DL_OVF <= 1'b1;
            end else if (gnt_pd) begin
                pd <= 1'b0;
            end
        end
    end

    assign O_BUSY = (state != ST_IDLE) || p1 || p2 || pd;

endmodule

// File: tb/tb_dkong3_snd_rom_arb.sv
// Bench for dkong3_snd_rom_arb. Two instances share all stimulus: dut_a uses
// MEM_LAT=1 and is the main subject, dut_b uses MEM_LAT=3 for the latency and
// reset checks. Each has its own memory model that returns rom_byte(addr)
// exactly MEM_LAT cycles after the RE cycle and zero at every other time.

module tb_dkong3_snd_rom_arb;

    logic        clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst;
    logic        s1_req;
    logic [12:0] s1_addr;
    logic        s2_req;
    logic [12:0] s2_addr;
    logic        dl_active;
    logic [16:0] dladdr;
    logic [7:0]  dldata;
    logic        dlwr;

    logic [13:0] a_addr;
    logic [7:0]  a_do;
    logic        a_we;
    logic        a_re;
    logic [7:0]  a_di;
    logic [7:0]  a_s1_do;
    logic        a_s1_v;
    logic [7:0]  a_s2_do;
    logic        a_s2_v;
    logic        a_ovf;
    logic        a_busy;

    logic [13:0] b_addr;
    logic [7:0]  b_do;
    logic        b_we;
    logic        b_re;
    logic [7:0]  b_di;
    logic [7:0]  b_s1_do;
    logic        b_s1_v;
    logic [7:0]  b_s2_do;
    logic        b_s2_v;
    logic        b_ovf;
    logic        b_busy;

    dkong3_snd_rom_arb #(.MEM_LAT(1)) dut_a (
        .I_CLK_24M(clk), .I_RST(rst),
        .I_SUB1_REQ(s1_req), .I_SUB1_ADDR(s1_addr),
        .I_SUB2_REQ(s2_req), .I_SUB2_ADDR(s2_addr),
        .I_DL_ACTIVE(dl_active), .I_DLADDR(dladdr), .I_DLDATA(dldata), .I_DLWR(dlwr),
        .O_MEM_ADDR(a_addr), .O_MEM_DO(a_do), .O_MEM_WE(a_we), .O_MEM_RE(a_re),
        .I_MEM_DI(a_di),
        .O_SUB1_DO(a_s1_do), .O_SUB1_VALID(a_s1_v),
        .O_SUB2_DO(a_s2_do), .O_SUB2_VALID(a_s2_v),
        .O_DL_OVF(a_ovf), .O_BUSY(a_busy)
    );

    dkong3_snd_rom_arb #(.MEM_LAT(3)) dut_b (
        .I_CLK_24M(clk), .I_RST(rst),
        .I_SUB1_REQ(s1_req), .I_SUB1_ADDR(s1_addr),
        .I_SUB2_REQ(s2_req), .I_SUB2_ADDR(s2_addr),
        .I_DL_ACTIVE(dl_active), .I_DLADDR(dladdr), .I_DLDATA(dldata), .I_DLWR(dlwr),
        .O_MEM_ADDR(b_addr), .O_MEM_DO(b_do), .O_MEM_WE(b_we), .O_MEM_RE(b_re),
        .I_MEM_DI(b_di),
        .O_SUB1_DO(b_s1_do), .O_SUB1_VALID(b_s1_v),
        .O_SUB2_DO(b_s2_do), .O_SUB2_VALID(b_s2_v),
        .O_DL_OVF(b_ovf), .O_BUSY(b_busy)
    );

    // Memory contents: a fixed pattern, 14'h1FFC holds 8'hA5.
    function automatic logic [7:0] rom_byte(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h46;
    endfunction

    logic [7:0] a_p;
    logic [7:0] b_p0;
    logic [7:0] b_p1;
    logic [7:0] b_p2;
    always @(posedge clk) begin
        a_p  <= a_re ? rom_byte(a_addr) : 8'h00;
        b_p0 <= b_re ? rom_byte(b_addr) : 8'h00;
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign a_di = a_p;
    assign b_di = b_p2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event logs sampled mid-cycle.
    logic [13:0] re_log[$];
    logic [21:0] wr_log[$];
    int          v1_cyc[$];
    logic [7:0]  v1_dat[$];
    int          v2_cyc[$];
    logic [7:0]  v2_dat[$];
    int          vb1_cyc[$];
    logic [7:0]  vb1_dat[$];

    always @(negedge clk) begin
        if (a_re) re_log.push_back(a_addr);
        if (a_we) wr_log.push_back({a_addr, a_do});
        if (a_s1_v) begin v1_cyc.push_back(cyc); v1_dat.push_back(a_s1_do); end
        if (a_s2_v) begin v2_cyc.push_back(cyc); v2_dat.push_back(a_s2_do); end
        if (b_s1_v) begin vb1_cyc.push_back(cyc); vb1_dat.push_back(b_s1_do); end
    end

    function automatic logic [13:0] re_at(input int i);
        return (i < re_log.size()) ? re_log[i] : 14'h3FFF;
    endfunction
    function automatic logic [21:0] wr_at(input int i);
        return (i < wr_log.size()) ? wr_log[i] : 22'h3FFFFF;
    endfunction
    function automatic int v1c_at(input int i);
        return (i < v1_cyc.size()) ? v1_cyc[i] : -1;
    endfunction
    function automatic logic [7:0] v1d_at(input int i);
        return (i < v1_dat.size()) ? v1_dat[i] : 8'hxx;
    endfunction
    function automatic int v2c_at(input int i);
        return (i < v2_cyc.size()) ? v2_cyc[i] : -1;
    endfunction
    function automatic logic [7:0] v2d_at(input int i);
        return (i < v2_dat.size()) ? v2_dat[i] : 8'hxx;
    endfunction

    int n_total = 0;
    int n_bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        s1_req    = 1'b0;
        s2_req    = 1'b0;
        dlwr      = 1'b0;
        dl_active = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s1_req  = 1'b1;
        s1_addr = 13'h0010;
        dlwr    = 1'b1;
        dladdr  = 17'h0A000;
        dldata  = 8'h77;
        tick();
        tick();
        s1_req = 1'b0;
        dlwr   = 1'b0;
        n_total++;
        if ({a_addr, a_do, a_we, a_re, a_s1_do, a_s1_v, a_s2_do, a_s2_v, a_ovf, a_busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_a_outputs got addr=%h do=%h we=%b re=%b s1=%h/%b s2=%h/%b ovf=%b busy=%b want all 0",
                     a_addr, a_do, a_we, a_re, a_s1_do, a_s1_v, a_s2_do, a_s2_v, a_ovf, a_busy);
        end
        n_total++;
        if ({b_addr, b_do, b_we, b_re, b_s1_do, b_s1_v, b_s2_do, b_s2_v, b_ovf, b_busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_b_outputs got addr=%h do=%h we=%b re=%b s1=%h/%b s2=%h/%b ovf=%b busy=%b want all 0",
                     b_addr, b_do, b_we, b_re, b_s1_do, b_s1_v, b_s2_do, b_s2_v, b_ovf, b_busy);
        end
        rst = 1'b0;
        tick();
        n_total++;
        if (a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_busy got=%b want=0", a_busy);
        end
    endtask

    task automatic test_latency();
        int s, b1, bb, bre;
        apply_reset();
        b1  = v1_cyc.size();
        bb  = vb1_cyc.size();
        bre = re_log.size();
        s1_req  = 1'b1;
        s1_addr = 13'h1FFC;
        tick();
        s1_req = 1'b0;
        s = cyc;
        tick();
        n_total++;
        if (a_re !== 1'b1 || a_addr !== 14'h1FFC) begin
            n_bad++;
            $display("FAIL lat_grant got re=%b addr=%h want re=1 addr=1ffc", a_re, a_addr);
        end
        n_total++;
        if (b_re !== 1'b1 || b_addr !== 14'h1FFC) begin
            n_bad++;
            $display("FAIL lat3_grant got re=%b addr=%h want re=1 addr=1ffc", b_re, b_addr);
        end
        tick();
        n_total++;
        if (a_re !== 1'b0) begin
            n_bad++;
            $display("FAIL lat_re_drop got=%b want=0", a_re);
        end
        repeat (6) tick();
        n_total++;
        if (re_log.size() - bre != 1) begin
            n_bad++;
            $display("FAIL lat_re_cycles got=%0d want=1", re_log.size() - bre);
        end
        n_total++;
        if (v1_cyc.size() - b1 != 1 || v1c_at(b1) - s != 3) begin
            n_bad++;
            $display("FAIL lat1_valid got pulses=%0d latency=%0d want pulses=1 latency=3",
                     v1_cyc.size() - b1, v1c_at(b1) - s);
        end
        n_total++;
        if (v1d_at(b1) !== 8'hA5 || a_s1_do !== 8'hA5) begin
            n_bad++;
            $display("FAIL lat1_data got pulse=%h held=%h want=a5", v1d_at(b1), a_s1_do);
        end
        n_total++;
        if (vb1_cyc.size() - bb != 1 || ((vb1_cyc.size() > bb) ? vb1_cyc[bb] - s : -1) != 5) begin
            n_bad++;
            $display("FAIL lat3_valid got pulses=%0d latency=%0d want pulses=1 latency=5",
                     vb1_cyc.size() - bb, (vb1_cyc.size() > bb) ? vb1_cyc[bb] - s : -1);
        end
        n_total++;
        if (b_s1_do !== 8'hA5) begin
            n_bad++;
            $display("FAIL lat3_data got=%h want=a5", b_s1_do);
        end
    endtask

    task automatic test_round_robin();
        int s, bre, bv1, bv2, fav, solo;
        logic [12:0] a1, a2;
        logic [13:0] e_first, e_second;
        apply_reset();
        fav = 1;
        for (int r = 0; r < 8; r++) begin
            // A solo read before odd rounds moves the tie-break pointer.
            if (r % 2 == 1) begin
                solo = (r % 4 == 1) ? 1 : 2;
                if (solo == 1) begin s1_req = 1'b1; s1_addr = 13'h0F00; end
                else           begin s2_req = 1'b1; s2_addr = 13'h0F00; end
                tick();
                s1_req = 1'b0;
                s2_req = 1'b0;
                repeat (6) tick();
                fav = (solo == 1) ? 2 : 1;
            end
            a1  = 13'(256 + r * 2);
            a2  = 13'(512 + r * 3);
            bre = re_log.size();
            bv1 = v1_cyc.size();
            bv2 = v2_cyc.size();
            s1_req  = 1'b1;
            s1_addr = a1;
            s2_req  = 1'b1;
            s2_addr = a2;
            tick();
            s1_req = 1'b0;
            s2_req = 1'b0;
            s = cyc;
            repeat (8) tick();
            e_first  = (fav == 1) ? {1'b0, a1} : {1'b1, a2};
            e_second = (fav == 1) ? {1'b1, a2} : {1'b0, a1};
            n_total++;
            if (re_log.size() - bre != 2 || re_at(bre) !== e_first || re_at(bre + 1) !== e_second) begin
                n_bad++;
                $display("FAIL rr_order round=%0d got n=%0d %h,%h want n=2 %h,%h",
                         r, re_log.size() - bre, re_at(bre), re_at(bre + 1), e_first, e_second);
            end
            n_total++;
            if (v1c_at(bv1) - s != ((fav == 1) ? 3 : 6) || v2c_at(bv2) - s != ((fav == 1) ? 6 : 3)) begin
                n_bad++;
                $display("FAIL rr_latency round=%0d got s1=%0d s2=%0d want s1=%0d s2=%0d",
                         r, v1c_at(bv1) - s, v2c_at(bv2) - s, (fav == 1) ? 3 : 6, (fav == 1) ? 6 : 3);
            end
            n_total++;
            if (v1d_at(bv1) !== rom_byte({1'b0, a1}) || v2d_at(bv2) !== rom_byte({1'b1, a2})) begin
                n_bad++;
                $display("FAIL rr_data round=%0d got s1=%h s2=%h want s1=%h s2=%h",
                         r, v1d_at(bv1), v2d_at(bv2), rom_byte({1'b0, a1}), rom_byte({1'b1, a2}));
            end
        end
    endtask

    task automatic test_dl_windows();
        logic [16:0] adr[3];
        logic [7:0]  dat[3];
        int bw;
        adr[0] = 17'h0A000; dat[0] = 8'h11;
        adr[1] = 17'h0DFFF; dat[1] = 8'h22;
        adr[2] = 17'h0E000; dat[2] = 8'h33;
        apply_reset();
        dl_active = 1'b1;
        bw = wr_log.size();
        for (int i = 0; i < 3; i++) begin
            dladdr = adr[i];
            dldata = dat[i];
            dlwr   = 1'b1;
            tick();
            dlwr = 1'b0;
            repeat (3) tick();
        end
        repeat (2) tick();
        n_total++;
        if (wr_log.size() - bw != 2) begin
            n_bad++;
            $display("FAIL dl_write_count got=%0d want=2", wr_log.size() - bw);
        end
        n_total++;
        if (wr_at(bw) !== {14'h0000, 8'h11}) begin
            n_bad++;
            $display("FAIL dl_write_sub1 got=%h want=%h", wr_at(bw), {14'h0000, 8'h11});
        end
        n_total++;
        if (wr_at(bw + 1) !== {14'h3FFF, 8'h22}) begin
            n_bad++;
            $display("FAIL dl_write_sub2 got=%h want=%h", wr_at(bw + 1), {14'h3FFF, 8'h22});
        end
        n_total++;
        if (a_ovf !== 1'b0 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL dl_spaced_ovf got ovf=%b busy=%b want ovf=0 busy=0", a_ovf, a_busy);
        end
        dl_active = 1'b0;
    endtask

    task automatic test_dl_active_block();
        int g, bre, bv1, bv2;
        apply_reset();
        dl_active = 1'b1;
        bre = re_log.size();
        bv1 = v1_cyc.size();
        bv2 = v2_cyc.size();
        s1_req  = 1'b1;
        s1_addr = 13'h0AAA;
        s2_req  = 1'b1;
        s2_addr = 13'h1555;
        tick();
        s1_req = 1'b0;
        s2_req = 1'b0;
        repeat (6) tick();
        n_total++;
        if (re_log.size() != bre || a_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL dlact_hold got re=%0d busy=%b want re=0 busy=1", re_log.size() - bre, a_busy);
        end
        dl_active = 1'b0;
        tick();
        g = cyc;
        repeat (7) tick();
        n_total++;
        if (re_log.size() - bre != 2 || re_at(bre) !== 14'h0AAA || re_at(bre + 1) !== 14'h3555) begin
            n_bad++;
            $display("FAIL dlact_grants got n=%0d %h,%h want n=2 0aaa,3555",
                     re_log.size() - bre, re_at(bre), re_at(bre + 1));
        end
        n_total++;
        if (v1c_at(bv1) - g != 2 || v2c_at(bv2) - g != 5) begin
            n_bad++;
            $display("FAIL dlact_latency got s1=%0d s2=%0d want s1=2 s2=5", v1c_at(bv1) - g, v2c_at(bv2) - g);
        end
        n_total++;
        if (v1d_at(bv1) !== rom_byte(14'h0AAA) || v2d_at(bv2) !== rom_byte(14'h3555)) begin
            n_bad++;
            $display("FAIL dlact_data got s1=%h s2=%h want s1=%h s2=%h",
                     v1d_at(bv1), v2d_at(bv2), rom_byte(14'h0AAA), rom_byte(14'h3555));
        end
    endtask

    task automatic test_overflow();
        int bw, bv1;
        apply_reset();
        bw  = wr_log.size();
        bv1 = v1_cyc.size();
        s1_req  = 1'b1;
        s1_addr = 13'h0040;
        tick();
        s1_req = 1'b0;
        dladdr = 17'h0A010;
        dldata = 8'h44;
        dlwr   = 1'b1;
        tick();
        dladdr = 17'h0A020;
        dldata = 8'h55;
        tick();
        dlwr = 1'b0;
        n_total++;
        if (a_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set got=%b want=1", a_ovf);
        end
        repeat (6) tick();
        n_total++;
        if (wr_log.size() - bw != 1 || wr_at(bw) !== {14'h0020, 8'h55}) begin
            n_bad++;
            $display("FAIL ovf_write got n=%0d %h want n=1 %h", wr_log.size() - bw, wr_at(bw), {14'h0020, 8'h55});
        end
        n_total++;
        if (v1_cyc.size() - bv1 != 1 || v1d_at(bv1) !== rom_byte(14'h0040)) begin
            n_bad++;
            $display("FAIL ovf_read got n=%0d data=%h want n=1 data=%h",
                     v1_cyc.size() - bv1, v1d_at(bv1), rom_byte(14'h0040));
        end
        n_total++;
        if (a_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky got=%b want=1", a_ovf);
        end
    endtask

    task automatic test_reset_mid();
        int s, bre, bv1, bv2;
        apply_reset();
        bre = re_log.size();
        bv1 = v1_cyc.size();
        bv2 = v2_cyc.size();
        s1_req  = 1'b1;
        s1_addr = 13'h0777;
        tick();
        s1_req  = 1'b0;
        s2_req  = 1'b1;
        s2_addr = 13'h0888;
        tick();
        s2_req = 1'b0;
        n_total++;
        if (a_re !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_granted got=%b want=1", a_re);
        end
        tick();
        rst = 1'b1;
        tick();
        n_total++;
        if ({a_addr, a_do, a_we, a_re, a_s1_do, a_s1_v, a_s2_do, a_s2_v, a_ovf, a_busy} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs got addr=%h we=%b re=%b s1=%h/%b s2=%h/%b busy=%b want all 0",
                     a_addr, a_we, a_re, a_s1_do, a_s1_v, a_s2_do, a_s2_v, a_busy);
        end
        rst = 1'b0;
        repeat (6) tick();
        n_total++;
        if (v1_cyc.size() != bv1 || v2_cyc.size() != bv2 || re_log.size() != bre + 1 || a_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_abandon got v1=%0d v2=%0d re=%0d busy=%b want v1=0 v2=0 re=1 busy=0",
                     v1_cyc.size() - bv1, v2_cyc.size() - bv2, re_log.size() - bre, a_busy);
        end
        s1_req  = 1'b1;
        s1_addr = 13'h0999;
        tick();
        s1_req = 1'b0;
        s = cyc;
        repeat (5) tick();
        n_total++;
        if (v1_cyc.size() - bv1 != 1 || v1c_at(bv1) - s != 3 || v1d_at(bv1) !== rom_byte(14'h0999)) begin
            n_bad++;
            $display("FAIL rstmid_fresh got n=%0d latency=%0d data=%h want n=1 latency=3 data=%h",
                     v1_cyc.size() - bv1, v1c_at(bv1) - s, v1d_at(bv1), rom_byte(14'h0999));
        end
    endtask

    task automatic test_same_edge();
        int s, bre, bv2;
        apply_reset();
        bre = re_log.size();
        bv2 = v2_cyc.size();
        s2_req  = 1'b1;
        s2_addr = 13'h0123;
        tick();
        s = cyc;
        s2_addr = 13'h0456;
        tick();
        s2_req = 1'b0;
        repeat (7) tick();
        n_total++;
        if (re_log.size() - bre != 2 || re_at(bre) !== 14'h2123 || re_at(bre + 1) !== 14'h2456) begin
            n_bad++;
            $display("FAIL same_edge_grants got n=%0d %h,%h want n=2 2123,2456",
                     re_log.size() - bre, re_at(bre), re_at(bre + 1));
        end
        n_total++;
        if (v2_cyc.size() - bv2 != 2 || v2c_at(bv2) - s != 3 || v2c_at(bv2 + 1) - s != 6) begin
            n_bad++;
            $display("FAIL same_edge_valid got n=%0d lat=%0d,%0d want n=2 lat=3,6",
                     v2_cyc.size() - bv2, v2c_at(bv2) - s, v2c_at(bv2 + 1) - s);
        end
        n_total++;
        if (v2d_at(bv2) !== rom_byte(14'h2123) || v2d_at(bv2 + 1) !== rom_byte(14'h2456) || a_s2_do !== rom_byte(14'h2456)) begin
            n_bad++;
            $display("FAIL same_edge_data got %h,%h held=%h want %h,%h",
                     v2d_at(bv2), v2d_at(bv2 + 1), a_s2_do, rom_byte(14'h2123), rom_byte(14'h2456));
        end
    endtask

    initial begin
        rst       = 1'b1;
        s1_req    = 1'b0;
        s1_addr   = '0;
        s2_req    = 1'b0;
        s2_addr   = '0;
        dl_active = 1'b0;
        dladdr    = '0;
        dldata    = '0;
        dlwr      = 1'b0;
        test_reset();
        test_latency();
        test_round_robin();
        test_dl_windows();
        test_dl_active_block();
        test_overflow();
        test_reset_mid();
        test_same_edge();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
